// File: rtl/fmap_serializer.sv
// Feature-map serializer: captures a ROWS x COLS map in one parallel transfer and streams it out
// one word per cycle. Define FMAP_SPARSE_SKIP_EN to skip zero-valued elements (last one always sent).
module fmap_serializer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ROWS   = 6,
  parameter int unsigned COLS   = 6,
  localparam int unsigned N     = ROWS * COLS,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                busy
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  state_e                state_q, state_d;
  logic [N*DATA_W-1:0]   buf_q, buf_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      first_idx, next_idx;
  logic                  is_last;

`ifdef FMAP_SPARSE_SKIP_EN
  logic [N-1:0] mask_q, mask_in;

  // Lowest set mask bit at or above start; bit N-1 is always set so a hit is guaranteed.
  function automatic logic [IDX_W-1:0] lowest_from(input logic [N-1:0] mask, input int start);
    logic [IDX_W-1:0] r;
    r = LastIdx;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i >= start && mask[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    mask_in = '0;
    for (int i = 0; i < int'(N); i++) begin
      mask_in[i] = |in_data[i*DATA_W +: DATA_W];
    end
    mask_in[N-1] = 1'b1;
  end

  assign first_idx = lowest_from(mask_in, 0);
  assign next_idx  = lowest_from(mask_q, int'(idx_q) + 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (in_ready && in_valid) begin
      mask_q <= mask_in;
    end
  end
`else
  assign first_idx = '0;
  assign next_idx  = idx_q + 1'b1;
`endif

  assign is_last = (idx_q == LastIdx);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          buf_d   = in_data;
          idx_d   = first_idx;
          state_d = StStream;
        end
      end
      StStream: begin
        if (out_ready) begin
          if (is_last) state_d = StIdle;
          else         idx_d   = next_idx;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = ~in_ready;
  assign out_valid = (state_q == StStream);
  // Outputs read as zero outside STREAM so IDLE always looks like the reset state.
  assign out_data  = out_valid ? buf_q[int'(idx_q)*DATA_W +: DATA_W] : '0;
  assign out_idx   = out_valid ? idx_q : '0;
  assign out_last  = out_valid & is_last;

endmodule

// File: tb/tb_fmap_serializer.sv
// Directed self-checking bench for fmap_serializer (default 6x6 map of 16-bit words).
module tb_fmap_serializer;

  localparam int DW = 16;
  localparam int NW = 36;

  logic             clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [NW*DW-1:0] in_data;
  logic [DW-1:0]    out_data;
  logic [5:0]       out_idx;

  int errors = 0;
  int checks = 0;

  fmap_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NW*DW-1:0] ramp_map();
    logic [NW*DW-1:0] m;
    for (int i = 0; i < NW; i++) m[i*DW +: DW] = DW'(i);
    return m;
  endfunction

  // Called at a negedge while idle; returns at the negedge after the capture edge.
  task automatic capture(input logic [NW*DW-1:0] m);
    in_data  = m;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
        out_idx !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b busy=%b vld=%b data=%h idx=%0d last=%b, want 1 0 0 0 0 0",
               in_ready, busy, out_valid, out_data, out_idx, out_last);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_out_ready: vld=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ramp();
    capture(ramp_map());
    out_ready = 1'b1;
    for (int k = 0; k < NW; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 6'(k) || out_data !== 16'(k) ||
          out_last !== 1'(k == NW - 1) || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL ramp word %0d: vld=%b idx=%0d data=%h last=%b rdy=%b, want 1 %0d %h %b 0",
                 k, out_valid, out_idx, out_data, out_last, in_ready, k, 16'(k), k == NW - 1);
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ramp_end: rdy=%b vld=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int exp_idx = 0;
    int cyc = 0;
    capture(ramp_map());
    while (exp_idx < NW && cyc < 200) begin
      out_ready = (cyc % 2 == 0);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 6'(exp_idx) || out_data !== 16'(exp_idx) ||
          out_last !== 1'(exp_idx == NW - 1)) begin
        errors++;
        $display("FAIL bp cycle %0d: vld=%b idx=%0d data=%h last=%b, want 1 %0d %h %b",
                 cyc, out_valid, out_idx, out_data, out_last, exp_idx, 16'(exp_idx),
                 exp_idx == NW - 1);
      end
      if (out_ready) exp_idx++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (exp_idx != NW || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: transfers=%0d rdy=%b vld=%b, want %0d 1 0",
               exp_idx, in_ready, out_valid, NW);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_lockout();
    capture(ramp_map());
    in_data  = '1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < NW; k++) begin
      checks++;
      if (in_ready !== 1'b0 || out_idx !== 6'(k) || out_data !== 16'(k)) begin
        errors++;
        $display("FAIL lockout word %0d: rdy=%b idx=%0d data=%h, want 0 %0d %h",
                 k, in_ready, out_idx, out_data, k, 16'(k));
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lockout_release: rdy=%b, want 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < NW; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 6'(k) || out_data !== 16'hFFFF) begin
        errors++;
        $display("FAIL lockout_ffff word %0d: vld=%b idx=%0d data=%h, want 1 %0d ffff",
                 k, out_valid, out_idx, out_data, k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_negative();
    logic [NW*DW-1:0] m;
    m = '0;
    m[7*DW +: DW]  = 16'h8000;
    m[20*DW +: DW] = 16'hFFFE;
    capture(m);
    out_ready = 1'b1;
    for (int k = 0; k < NW; k++) begin
      logic [DW-1:0] want;
      want = (k == 7) ? 16'h8000 : (k == 20) ? 16'hFFFE : 16'h0000;
      checks++;
      if (out_idx !== 6'(k) || out_data !== want) begin
        errors++;
        $display("FAIL negative word %0d: idx=%0d data=%h, want %0d %h",
                 k, out_idx, out_data, k, want);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_midreset();
    capture(ramp_map());
    out_ready = 1'b1;
    // Let idx 0..10 transfer; we stop at the negedge showing idx 11.
    for (int k = 0; k < 11; k++) @(negedge clk);
    checks++;
    if (out_idx !== 6'd11) begin
      errors++;
      $display("FAIL midreset_pre: idx=%0d, want 11", out_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_idx !== '0 ||
        out_data !== '0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL midreset: vld=%b rdy=%b busy=%b idx=%0d data=%h last=%b, want 0 1 0 0 0 0",
               out_valid, in_ready, busy, out_idx, out_data, out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    capture(ramp_map());
    for (int k = 0; k < NW; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 6'(k) || out_data !== 16'(k)) begin
        errors++;
        $display("FAIL midreset_restart word %0d: vld=%b idx=%0d data=%h, want 1 %0d %h",
                 k, out_valid, out_idx, out_data, k, 16'(k));
      end
      @(negedge clk);
    end
  endtask

`ifdef FMAP_SPARSE_SKIP_EN
  task automatic test_sparse();
    logic [NW*DW-1:0] m;
    int               eidx [3] = '{3, 17, 35};
    logic [DW-1:0]    edat [3] = '{16'h0005, 16'h7FFF, 16'h0000};
    m = '0;
    m[3*DW +: DW]  = 16'h0005;
    m[17*DW +: DW] = 16'h7FFF;
    capture(m);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 6'(eidx[k]) || out_data !== edat[k] ||
          out_last !== 1'(k == 2)) begin
        errors++;
        $display("FAIL sparse word %0d: vld=%b idx=%0d data=%h last=%b, want 1 %0d %h %b",
                 k, out_valid, out_idx, out_data, out_last, eidx[k], edat[k], k == 2);
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sparse_end: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    capture('0);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 6'd35 || out_data !== 16'h0000 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL sparse_zero: vld=%b idx=%0d data=%h last=%b, want 1 35 0000 1",
               out_valid, out_idx, out_data, out_last);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sparse_zero_end: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef FMAP_SPARSE_SKIP_EN
    test_sparse();
`else
    test_ramp();
    test_backpressure();
    test_lockout();
    test_negative();
    test_midreset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
